// File: rtl/cp0_pkg.sv
// Shared cp0 event types used by the commit-stage exception arbiter.
// Lane 0 is always the older instruction of the issue pair.
package cp0_pkg;

  typedef struct packed {
    logic bad_vaddr_f;
    logic reserve_instr;
    logic overflow;
    logic trap;
    logic syscall;
    logic adel_d;
    logic ades_d;
  } excp_type_t;

  typedef enum logic {
    NONE,
    EXCEPTION
  } cp0_type_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_INT,
    EV_EXC,
    EV_ERET
  } event_kind_t;

  localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

endpackage

// File: rtl/excp_pick.sv
// Combinational priority pick of the single architectural event per cycle.
// Order: interrupt, lane-0 exception, lane-0 eret, lane-1 exception, lane-1 eret.
module excp_pick
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic                  int_req,
  input  logic [1:0]            lane_valid,
  input  excp_type_t [1:0]      lane_etype,
  input  logic [1:0]            lane_eret,
  input  logic [31:0]           cp0_epc,
  output event_kind_t           kind,
  output logic                  lane,
  output logic [31:0]           target
);

  logic [1:0] exc;
  logic [1:0] ert;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      exc[i] = lane_valid[i] && (|lane_etype[i]);
      ert[i] = lane_valid[i] && lane_eret[i];
    end
  end

  always_comb begin
    kind   = EV_NONE;
    lane   = 1'b0;
    target = '0;
    if (int_req && lane_valid[0]) begin
      kind   = EV_INT;
      target = EXC_VECTOR;
    end else if (exc[0]) begin
      kind   = EV_EXC;
      target = EXC_VECTOR;
    end else if (ert[0]) begin
      kind   = EV_ERET;
      target = cp0_epc;
    end else if (exc[1]) begin
      kind   = EV_EXC;
      lane   = 1'b1;
      target = EXC_VECTOR;
    end else if (ert[1]) begin
      kind   = EV_ERET;
      lane   = 1'b1;
      target = cp0_epc;
    end
  end

endmodule

// File: rtl/excp_commit_arbiter.sv
// Commit-stage arbiter: one cp0 event per cycle, lane commit, flush,
// and a redirect to fetch that is held until fetch accepts it.
module excp_commit_arbiter
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter int          NLANE      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NLANE-1:0]            lane_valid,
  input  logic [NLANE-1:0][31:0]      lane_pc,
  input  logic [NLANE-1:0]            lane_slot,
  input  excp_type_t [NLANE-1:0]      lane_etype,
  input  logic [NLANE-1:0]            lane_eret,
  input  logic [NLANE-1:0][31:0]      lane_vaddr,
  input  logic                        int_req,
  input  logic [31:0]                 cp0_epc,
  input  logic                        redirect_ready,
  output cp0_type_t                   cp0_ctype,
  output excp_type_t                  cp0_etype,
  output logic [31:0]                 cp0_pc,
  output logic [31:0]                 cp0_vaddr,
  output logic                        cp0_is_slot,
  output logic                        cp0_is_eret,
  output logic                        cp0_inter_valid,
  output logic [31:0]                 cp0_int_pc,
  output logic [NLANE-1:0]            commit,
  output logic                        flush,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] redirect_pc_q;
  event_kind_t pick_kind;
  event_kind_t ev;
  logic        pick_lane;
  logic [31:0] pick_target;
  logic        hold;

  excp_pick #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pick (
    .int_req    (int_req),
    .lane_valid (lane_valid),
    .lane_etype (lane_etype),
    .lane_eret  (lane_eret),
    .cp0_epc    (cp0_epc),
    .kind       (pick_kind),
    .lane       (pick_lane),
    .target     (pick_target)
  );

  assign hold = (state == HOLD) && !reset;
  assign ev   = (state == IDLE && !stall && !reset) ? pick_kind : EV_NONE;

  always_comb begin
    commit = '0;
    if (!reset && !stall && state == IDLE)
      commit = (ev == EV_NONE) ? lane_valid : {1'b0, pick_lane};
  end

  always_comb begin
    flush          = hold || (ev != EV_NONE);
    redirect_valid = flush;
    redirect_pc    = '0;
    if (hold)
      redirect_pc = redirect_pc_q;
    else if (ev != EV_NONE)
      redirect_pc = pick_target;
  end

  always_comb begin
    cp0_ctype       = NONE;
    cp0_etype       = '0;
    cp0_pc          = '0;
    cp0_vaddr       = '0;
    cp0_is_slot     = 1'b0;
    cp0_is_eret     = 1'b0;
    cp0_inter_valid = 1'b0;
    cp0_int_pc      = '0;
    if (ev != EV_NONE) begin
      cp0_pc      = lane_pc[pick_lane];
      cp0_vaddr   = lane_vaddr[pick_lane];
      cp0_is_slot = lane_slot[pick_lane];
    end
    case (ev)
      EV_INT: begin
        cp0_inter_valid = 1'b1;
        // return to the branch when the victim sits in its delay slot
        cp0_int_pc = lane_slot[0] ? lane_pc[0] - 32'd4 : lane_pc[0];
      end
      EV_EXC: begin
        cp0_ctype = EXCEPTION;
        cp0_etype = lane_etype[pick_lane];
      end
      EV_ERET: cp0_is_eret = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      redirect_pc_q <= '0;
    end else begin
      case (state)
        IDLE: if (ev != EV_NONE && !redirect_ready) begin
          state         <= HOLD;
          redirect_pc_q <= pick_target;
        end
        HOLD: if (redirect_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_excp_commit_arbiter.sv
// Bench for excp_commit_arbiter: directed table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_excp_commit_arbiter;
  import cp0_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam excp_type_t ET_0   = '{default: 1'b0};
  localparam excp_type_t ET_OVF = '{overflow: 1'b1, default: 1'b0};
  localparam excp_type_t ET_SYS = '{syscall: 1'b1, default: 1'b0};
  localparam excp_type_t ET_RI  = '{reserve_instr: 1'b1, default: 1'b0};
  localparam excp_type_t ET_ADS = '{ades_d: 1'b1, default: 1'b0};

  logic clk = 1'b0;
  logic reset, stall, int_req, redirect_ready;
  logic [1:0] lane_valid, lane_slot, lane_eret;
  logic [1:0][31:0] lane_pc, lane_vaddr;
  excp_type_t [1:0] lane_etype;
  logic [31:0] cp0_epc;
  cp0_type_t cp0_ctype;
  excp_type_t cp0_etype;
  logic [31:0] cp0_pc, cp0_vaddr, cp0_int_pc, redirect_pc;
  logic cp0_is_slot, cp0_is_eret, cp0_inter_valid;
  logic [1:0] commit;
  logic flush, redirect_valid;

  always #5 clk = ~clk;

  excp_commit_arbiter dut (
    .clk(clk), .reset(reset), .stall(stall),
    .lane_valid(lane_valid), .lane_pc(lane_pc),
    .lane_slot(lane_slot), .lane_etype(lane_etype),
    .lane_eret(lane_eret), .lane_vaddr(lane_vaddr),
    .int_req(int_req), .cp0_epc(cp0_epc),
    .redirect_ready(redirect_ready),
    .cp0_ctype(cp0_ctype), .cp0_etype(cp0_etype),
    .cp0_pc(cp0_pc), .cp0_vaddr(cp0_vaddr),
    .cp0_is_slot(cp0_is_slot), .cp0_is_eret(cp0_is_eret),
    .cp0_inter_valid(cp0_inter_valid), .cp0_int_pc(cp0_int_pc),
    .commit(commit), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  task automatic clear_in();
    reset = 1'b0; stall = 1'b0; int_req = 1'b0;
    redirect_ready = 1'b1;
    lane_valid = 2'b11; lane_slot = 2'b00; lane_eret = 2'b00;
    lane_pc[0] = 32'h8000_0000; lane_pc[1] = 32'h8000_0004;
    lane_vaddr[0] = 32'h1000_0000; lane_vaddr[1] = 32'hCAFE_0001;
    lane_etype[0] = ET_0; lane_etype[1] = ET_0;
    cp0_epc = 32'h0;
  endtask

  typedef struct {
    logic irq; logic [1:0] v; logic [31:0] pc0, pc1;
    logic [1:0] slot; excp_type_t et0, et1; logic [1:0] eret;
    logic [31:0] epc;
    logic [1:0] x_commit; logic x_flush; logic [31:0] x_rpc;
    logic x_exc; logic [31:0] x_cpc; logic x_int;
    logic [31:0] x_ipc; logic x_eret; logic x_slot;
  } vec_t;

  vec_t tv[12];

  // reference model: pending redirect targets not yet accepted by fetch
  logic [31:0] pend_q[$];

  typedef struct packed {
    logic [1:0] commit; logic flush; logic rv; logic [31:0] rpc;
    logic exc; logic [6:0] et; logic [31:0] cpc; logic [31:0] cva;
    logic slot; logic eret; logic inter; logic [31:0] ipc;
    logic detail;
  } obs_t;

  function automatic void pick(output int kind, output int ln,
                               output logic [31:0] tgt);
    kind = 0; ln = 0;
    if (int_req && lane_valid[0]) kind = 1;
    for (int l = 0; l < 2; l++) begin
      if (kind == 0 && lane_valid[l]) begin
        if (lane_etype[l] != ET_0) begin kind = 2; ln = l; end
        else if (lane_eret[l]) begin kind = 3; ln = l; end
      end
    end
    tgt = (kind == 3) ? cp0_epc : VEC;
  endfunction

  function automatic obs_t ref_out();
    obs_t e; int kind; int ln; logic [31:0] tgt;
    e = '0; e.detail = 1'b1;
    if (reset) return e;
    if (pend_q.size() != 0) begin
      e.flush = 1'b1; e.rv = 1'b1; e.rpc = pend_q[0];
      return e;
    end
    if (stall) return e;
    pick(kind, ln, tgt);
    if (kind == 0) begin e.commit = lane_valid; return e; end
    e.flush = 1'b1; e.rv = 1'b1; e.rpc = tgt;
    e.commit = (ln == 1) ? 2'b01 : 2'b00;
    e.slot = lane_slot[ln];
    case (kind)
      1: begin
        e.inter = 1'b1; e.detail = 1'b0;
        e.ipc = lane_pc[0] - (lane_slot[0] ? 32'd4 : 32'd0);
      end
      2: begin
        e.exc = 1'b1; e.et = lane_etype[ln];
        e.cpc = lane_pc[ln]; e.cva = lane_vaddr[ln];
      end
      default: begin e.eret = 1'b1; e.detail = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic void ref_step();
    int kind; int ln; logic [31:0] tgt;
    pick(kind, ln, tgt);
    if (reset) pend_q.delete();
    else if (pend_q.size() != 0) begin
      if (redirect_ready) void'(pend_q.pop_front());
    end else if (!stall && kind != 0 && !redirect_ready)
      pend_q.push_back(tgt);
  endfunction

  function automatic obs_t dut_obs(input logic detail);
    obs_t g;
    g.commit = commit; g.flush = flush; g.rv = redirect_valid;
    g.rpc = redirect_pc; g.exc = (cp0_ctype == EXCEPTION);
    g.et = cp0_etype; g.cpc = cp0_pc; g.cva = cp0_vaddr;
    g.slot = cp0_is_slot; g.eret = cp0_is_eret;
    g.inter = cp0_inter_valid; g.ipc = cp0_int_pc;
    g.detail = detail;
    if (!detail) begin g.et = '0; g.cpc = '0; g.cva = '0; end
    return g;
  endfunction

  initial begin
    // irq v pc0 pc1 slot et0 et1 eret epc | commit flush rpc exc cpc int ipc eret slot
    tv[0]  = '{0, 2'b11, 32'h8000_0100, 32'h8000_0104, 2'b00, ET_OVF, ET_0, 2'b00, 0,
               2'b00, 1, VEC, 1, 32'h8000_0100, 0, 0, 0, 0};
    tv[1]  = '{0, 2'b11, 32'h8000_0200, 32'h8000_0204, 2'b10, ET_0, ET_SYS, 2'b00, 0,
               2'b01, 1, VEC, 1, 32'h8000_0204, 0, 0, 0, 1};
    tv[2]  = '{1, 2'b11, 32'h8000_0008, 32'h8000_000C, 2'b01, ET_RI, ET_0, 2'b00, 0,
               2'b00, 1, VEC, 0, 0, 1, 32'h8000_0004, 0, 1};
    tv[3]  = '{1, 2'b11, 32'h8000_0010, 32'h8000_0014, 2'b00, ET_0, ET_0, 2'b00, 0,
               2'b00, 1, VEC, 0, 0, 1, 32'h8000_0010, 0, 0};
    tv[4]  = '{0, 2'b11, 32'h8000_0020, 32'h8000_0024, 2'b00, ET_0, ET_SYS, 2'b01,
               32'h8000_1000, 2'b00, 1, 32'h8000_1000, 0, 0, 0, 0, 1, 0};
    tv[5]  = '{0, 2'b11, 32'h8000_0030, 32'h8000_0034, 2'b00, ET_0, ET_0, 2'b10,
               32'h8000_2000, 2'b01, 1, 32'h8000_2000, 0, 0, 0, 0, 1, 0};
    tv[6]  = '{0, 2'b11, 32'h8000_0040, 32'h8000_0044, 2'b00, ET_0, ET_0, 2'b00, 0,
               2'b11, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[7]  = '{0, 2'b10, 32'h8000_0050, 32'h8000_0054, 2'b00, ET_OVF, ET_0, 2'b00, 0,
               2'b10, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[8]  = '{1, 2'b10, 32'h8000_0060, 32'h8000_0064, 2'b00, ET_0, ET_0, 2'b00, 0,
               2'b10, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[9]  = '{0, 2'b11, 32'h8000_0070, 32'h8000_0074, 2'b00, ET_ADS, ET_SYS, 2'b00, 0,
               2'b00, 1, VEC, 1, 32'h8000_0070, 0, 0, 0, 0};
    tv[10] = '{0, 2'b11, 32'h8000_0300, 32'h8000_0304, 2'b00, ET_OVF, ET_0, 2'b01,
               32'h8000_3000, 2'b00, 1, VEC, 1, 32'h8000_0300, 0, 0, 0, 0};
    tv[11] = '{1, 2'b11, 32'h0000_0000, 32'h0000_0004, 2'b01, ET_0, ET_0, 2'b00, 0,
               2'b00, 1, VEC, 0, 0, 1, 32'hFFFF_FFFC, 0, 1};

    clear_in();
    reset = 1'b1;
    @(negedge clk); #1;
    chk("reset commit", commit, 2'b00);
    chk("reset flush", flush, 0);
    chk("reset rvalid", redirect_valid, 0);
    chk("reset rpc", redirect_pc, 0);
    chk("reset ctype", cp0_ctype == EXCEPTION, 0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      clear_in();
      int_req = tv[i].irq; lane_valid = tv[i].v;
      lane_pc[0] = tv[i].pc0; lane_pc[1] = tv[i].pc1;
      lane_slot = tv[i].slot; lane_eret = tv[i].eret;
      lane_etype[0] = tv[i].et0; lane_etype[1] = tv[i].et1;
      cp0_epc = tv[i].epc;
      #1;
      chk($sformatf("v%0d commit", i), commit, tv[i].x_commit);
      chk($sformatf("v%0d flush", i), flush, tv[i].x_flush);
      chk($sformatf("v%0d rvalid", i), redirect_valid, tv[i].x_flush);
      chk($sformatf("v%0d rpc", i), redirect_pc, tv[i].x_rpc);
      chk($sformatf("v%0d ctype", i), cp0_ctype == EXCEPTION, tv[i].x_exc);
      chk($sformatf("v%0d inter", i), cp0_inter_valid, tv[i].x_int);
      chk($sformatf("v%0d int_pc", i), cp0_int_pc, tv[i].x_ipc);
      chk($sformatf("v%0d eret", i), cp0_is_eret, tv[i].x_eret);
      chk($sformatf("v%0d slot", i), cp0_is_slot, tv[i].x_slot);
      if (tv[i].x_exc || !tv[i].x_flush)
        chk($sformatf("v%0d cp0_pc", i), cp0_pc, tv[i].x_cpc);
      @(negedge clk);
    end

    // eret with fetch back-pressure: held redirect, later events ignored
    clear_in();
    lane_eret = 2'b01; cp0_epc = 32'h8000_1000; redirect_ready = 1'b0;
    #1;
    chk("eret pulse", cp0_is_eret, 1);
    chk("eret rpc", redirect_pc, 32'h8000_1000);
    chk("eret flush", flush, 1);
    chk("eret commit", commit, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      clear_in();
      lane_etype[0] = ET_OVF; int_req = 1'b1;
      cp0_epc = 32'h8000_5555; redirect_ready = (k == 3);
      #1;
      chk($sformatf("hold%0d eret", k), cp0_is_eret, 0);
      chk($sformatf("hold%0d ctype", k), cp0_ctype == EXCEPTION, 0);
      chk($sformatf("hold%0d inter", k), cp0_inter_valid, 0);
      chk($sformatf("hold%0d rvalid", k), redirect_valid, 1);
      chk($sformatf("hold%0d rpc", k), redirect_pc, 32'h8000_1000);
      chk($sformatf("hold%0d flush", k), flush, 1);
      chk($sformatf("hold%0d commit", k), commit, 2'b00);
    end
    @(negedge clk);
    clear_in(); #1;
    chk("post-hold rvalid", redirect_valid, 0);
    chk("post-hold commit", commit, 2'b11);

    // stall masks a pending adesD until it drops
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      clear_in();
      stall = 1'b1; lane_etype[0] = ET_ADS; lane_vaddr[0] = 32'h1000_0003;
      #1;
      chk($sformatf("stall%0d ctype", k), cp0_ctype == EXCEPTION, 0);
      chk($sformatf("stall%0d commit", k), commit, 2'b00);
      chk($sformatf("stall%0d flush", k), flush, 0);
      @(negedge clk);
    end
    stall = 1'b0; #1;
    chk("unstall ctype", cp0_ctype == EXCEPTION, 1);
    chk("unstall vaddr", cp0_vaddr, 32'h1000_0003);
    chk("unstall etype", cp0_etype, ET_ADS);
    @(negedge clk);
    clear_in(); #1;
    chk("once ctype", cp0_ctype == EXCEPTION, 0);

    // reset while holding a redirect
    @(negedge clk);
    clear_in(); lane_etype[1] = ET_SYS; redirect_ready = 1'b0;
    @(negedge clk);
    clear_in(); redirect_ready = 1'b0; #1;
    chk("pre-reset rvalid", redirect_valid, 1);
    reset = 1'b1; #1;
    chk("in-reset rvalid", redirect_valid, 0);
    @(negedge clk);
    clear_in(); redirect_ready = 1'b0; #1;
    chk("after-reset rvalid", redirect_valid, 0);
    chk("after-reset flush", flush, 0);
    chk("after-reset commit", commit, 2'b11);

    // random traffic vs reference model
    @(negedge clk);
    clear_in(); reset = 1'b1; pend_q.delete();
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      obs_t e; obs_t g;
      reset = ($urandom_range(49) == 0);
      stall = ($urandom_range(7) == 0);
      int_req = ($urandom_range(7) == 0);
      redirect_ready = $urandom_range(1);
      lane_valid = 2'($urandom_range(3));
      lane_slot = 2'($urandom_range(3));
      lane_eret[0] = ($urandom_range(7) == 0);
      lane_eret[1] = ($urandom_range(7) == 0);
      cp0_epc = $urandom;
      for (int l = 0; l < 2; l++) begin
        lane_pc[l] = $urandom;
        lane_vaddr[l] = $urandom;
        lane_etype[l] = ($urandom_range(3) == 0) ?
          excp_type_t'(7'(1 << $urandom_range(6))) : ET_0;
      end
      #1;
      e = ref_out();
      g = dut_obs(e.detail);
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL rand%0d: got %h, want %h", c, g, e);
      end
      ref_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
